// File: rtl/id_seq_pkg.sv
// Shared types and constants for the ID digit sequencer.
package id_seq_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam digit_t DIGIT_RESET = 4'd0;

endpackage

// File: rtl/id_seq_ctrl_gap_timer.sv
// Inter-digit gap countdown: loads a value, counts down to zero unless held.
module gap_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         hold_i,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/id_seq_ctrl.sv
// Commanded ID digit sequencer: emits table entries 0..len-1 over valid/ready with gaps.
// Optional SEQ_LOOP_EN adds a 'loop' input that restarts the sequence instead of completing.
module id_seq_ctrl
    import id_seq_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [3:0]    cfg_data,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
`ifdef SEQ_LOOP_EN
    input  logic          loop,
`endif
    output logic [3:0]    digit,
    output logic          digit_valid,
    input  logic          digit_ready,
    output logic [AW-1:0] idx,
    output logic          busy,
    output logic          done
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TICK_DIV + 1);

    seq_state_t    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    digit_t        digit_q, digit_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    digit_t        tbl_q [DEPTH];

    logic          gap_load_c;
    logic          gap_zero_c;
    logic          loop_c;
    logic          last_c;
    logic [LW-1:0] len_clip_c;

`ifdef SEQ_LOOP_EN
    assign loop_c = loop;
`else
    assign loop_c = 1'b0;
`endif

    assign len_clip_c = (32'(len) > DEPTH) ? LW'(DEPTH) : len;
    assign last_c     = ((LW'(idx_q) + LW'(1)) == len_q);

    gap_timer #(.W(CW)) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gap_load_c),
        .load_val_i (CW'(TICK_DIV - 1)),
        .hold_i     (hold),
        .zero_c     (gap_zero_c)
    );

    // Next-state and output decode; stop overrides everything.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        digit_d    = digit_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        gap_load_c = 1'b0;

        if (stop) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        len_d = len_clip_c;
                        idx_d = '0;
                        if (len_clip_c == '0) begin
                            done_d = 1'b1;
                        end else begin
                            done_d  = 1'b0;
                            state_d = EMIT;
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                            digit_d = tbl_q[0];
                        end
                    end
                end
                EMIT: begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    if (digit_ready) begin
                        valid_d = 1'b0;
                        if (last_c && !loop_c) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = GAP;
                            idx_d      = last_c ? '0 : idx_q + AW'(1);
                            gap_load_c = 1'b1;
                        end
                    end
                end
                GAP: begin
                    busy_d = 1'b1;
                    if (!hold && gap_zero_c) begin
                        state_d = EMIT;
                        valid_d = 1'b1;
                        digit_d = tbl_q[idx_q];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            digit_q <= DIGIT_RESET;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Table is writable only between sequences so a running sequence never changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_q[i] <= DIGIT_RESET;
            end
        end else if (cfg_we && !busy_q && (32'(cfg_addr) < DEPTH)) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign idx         = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_id_seq_ctrl.sv
// Self-checking bench for id_seq_ctrl: reference model plus directed scenarios.
module tb_id_seq_ctrl;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned AW       = 3;
    localparam int unsigned LW       = 4;

    logic          clk = 1'b0;
    logic          reset, cfg_we, start, stop, hold, digit_ready;
    logic          digit_valid, busy, done;
    logic [AW-1:0] cfg_addr, idx;
    logic [3:0]    cfg_data, digit;
    logic [LW-1:0] len;
`ifdef SEQ_LOOP_EN
    logic          loop;
`endif

    always #5 clk = ~clk;

    id_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .len         (len),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
`ifdef SEQ_LOOP_EN
        .loop        (loop),
`endif
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .idx         (idx),
        .busy        (busy),
        .done        (done)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    int tab [8] = '{3, 1, 4, 1, 5, 9, 2, 6};

    // Model state: expected outputs derived from the sequencing rules.
    int m_tbl [DEPTH];
    bit m_active, m_pres, m_done;
    int m_pos, m_len, m_gap, m_digit;

    int log_d[$];
    int log_c[$];
    int idx2_cycles;
    int start_cyc;

    int stall_idx = -1, stall_left = 0;
    int hold_idx  = -1, hold_left  = 0;
    int stop_idx  = -1, stopx_idx  = -1;
    bit we_busy   = 1'b0;
    int we_addr, we_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_step();
        int  n;
        bit  wr_ok;
        bit  lp;
        cyc++;
        if (reset) begin
            foreach (m_tbl[i]) m_tbl[i] = 0;
            m_active = 0; m_pres = 0; m_done = 0;
            m_pos = 0; m_len = 0; m_gap = 0; m_digit = 0;
            return;
        end
        wr_ok = cfg_we && !m_active && (int'(cfg_addr) < int'(DEPTH));
`ifdef SEQ_LOOP_EN
        lp = loop;
`else
        lp = 1'b0;
`endif
        if (stop) begin
            m_active = 0; m_pres = 0; m_pos = 0;
        end else if (!m_active) begin
            if (start) begin
                n = (int'(len) < int'(DEPTH)) ? int'(len) : int'(DEPTH);
                m_pos = 0;
                if (n == 0) m_done = 1;
                else begin
                    m_done = 0; m_len = n; m_active = 1; m_pres = 1; m_digit = m_tbl[0];
                end
            end
        end else if (m_pres) begin
            if (digit_ready) begin
                m_pres = 0;
                if (m_pos == m_len - 1) begin
                    m_pos = 0;
                    if (lp) m_gap = TICK_DIV;
                    else begin m_active = 0; m_done = 1; end
                end else begin
                    m_pos++;
                    m_gap = TICK_DIV;
                end
            end
        end else if (!hold) begin
            m_gap--;
            if (m_gap == 0) begin m_pres = 1; m_digit = m_tbl[m_pos]; end
        end
        if (wr_ok) m_tbl[cfg_addr] = int'(cfg_data);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare and transfer log, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("valid", 32'(digit_valid), 32'(m_pres));
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("idx", 32'(idx), 32'(m_pos));
            if (m_pres) chk("digit", 32'(digit), 32'(m_digit));
            if (digit_valid && digit_ready) begin
                log_d.push_back(int'(digit));
                log_c.push_back(cyc);
            end
            if (digit_valid && idx == 3'd2) idx2_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = 4'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic drive_ctrl();
        digit_ready = 1'b1; hold = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        if (digit_valid && int'(idx) == stall_idx && stall_left > 0) begin
            digit_ready = 1'b0; stall_left--;
        end
        if (busy && !digit_valid && int'(idx) == hold_idx && hold_left > 0) begin
            hold = 1'b1; hold_left--;
        end
        if (busy && !digit_valid && int'(idx) == stop_idx) begin
            stop = 1'b1; stop_idx = -1;
        end
        if (digit_valid && int'(idx) == stopx_idx) begin
            stop = 1'b1; digit_ready = 1'b1; stopx_idx = -1;
        end
        if (busy && we_busy) begin
            cfg_we = 1'b1; cfg_addr = AW'(we_addr); cfg_data = 4'(we_data); we_busy = 1'b0;
        end
    endtask

    task automatic run_seq(input int l, input int budget);
        int n = 0;
        log_d.delete(); log_c.delete();
        start_cyc = cyc;
        drive_ctrl();
        start = 1'b1; len = LW'(l);
        tick();
        start = 1'b0;
        while (busy && n < budget) begin
            drive_ctrl();
            tick();
            n++;
        end
        drive_ctrl();
        chk("seq_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; len = '0;
        start = 1'b0; stop = 1'b0; hold = 1'b0; digit_ready = 1'b1;
`ifdef SEQ_LOOP_EN
        loop = 1'b0;
`endif
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) write_tbl(i, tab[i]);

        // Plain five-digit run.
        run_seq(5, 200);
        chk("t1_count", 32'(log_d.size()), 32'd5);
        for (int k = 0; k < 5; k++) chk("t1_digit", 32'(log_d[k]), 32'(tab[k]));
        for (int k = 0; k < 4; k++) chk("t1_spacing", 32'(log_c[k+1] - log_c[k]), 32'd5);
        chk("t1_latency", 32'(log_c[0] - start_cyc), 32'd1);
        chk("t1_done_lat", 32'(cyc - log_c[4]), 32'd1);
        chk("t1_done", 32'(done), 32'd1);

        // Backpressure on idx 2.
        stall_idx = 2; stall_left = 3; idx2_cycles = 0;
        run_seq(5, 200);
        chk("t2_count", 32'(log_d.size()), 32'd5);
        chk("t2_digit2", 32'(log_d[2]), 32'd4);
        chk("t2_idx2_cycles", 32'(idx2_cycles), 32'd4);
        chk("t2_spacing", 32'(log_c[2] - log_c[1]), 32'd8);
        stall_idx = -1;

        // Abort in the gap after idx 1.
        stop_idx = 2;
        run_seq(5, 200);
        chk("t3_count", 32'(log_d.size()), 32'd2);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_idx", 32'(idx), 32'd0);
        chk("t3_valid", 32'(digit_valid), 32'd0);

        // Zero-length start.
        run_seq(0, 10);
        chk("t4_done", 32'(done), 32'd1);
        repeat (3) tick();
        chk("t4_no_digits", 32'(log_d.size()), 32'd0);

        run_seq(5, 200);
        chk("t3_replay_first", 32'(log_d[0]), 32'd3);
        chk("t3_replay_count", 32'(log_d.size()), 32'd5);

        // Over-long length is clipped to the table depth.
        run_seq(12, 400);
        chk("t5_count", 32'(log_d.size()), 32'd8);
        chk("t5_last", 32'(log_d[7]), 32'd6);

        // Hold in the first gap, write attempted while busy.
        hold_idx = 1; hold_left = 5; we_busy = 1'b1; we_addr = 0; we_data = 8;
        run_seq(5, 200);
        chk("t6_hold_spacing", 32'(log_c[1] - log_c[0]), 32'd10);
        chk("t6_next_spacing", 32'(log_c[2] - log_c[1]), 32'd5);
        hold_idx = -1;
        run_seq(2, 100);
        chk("t6_tbl_unchanged", 32'(log_d[0]), 32'd3);

        // Abort coincident with a transfer.
        stopx_idx = 1;
        run_seq(5, 200);
        chk("t7_count", 32'(log_d.size()), 32'd2);
        chk("t7_last", 32'(log_d[1]), 32'd1);
        chk("t7_done", 32'(done), 32'd0);

        // Reset mid-stream clears outputs and table.
        start = 1'b1; len = LW'(5);
        tick();
        start = 1'b0;
        repeat (7) begin drive_ctrl(); tick(); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t8_valid", 32'(digit_valid), 32'd0);
        chk("t8_busy", 32'(busy), 32'd0);
        chk("t8_idx", 32'(idx), 32'd0);
        chk("t8_digit", 32'(digit), 32'd0);
        run_seq(2, 100);
        chk("t8_count", 32'(log_d.size()), 32'd2);
        chk("t8_cleared", 32'(log_d[1]), 32'd0);

`ifdef SEQ_LOOP_EN
        // Looping two-digit sequence.
        write_tbl(0, 7);
        write_tbl(1, 9);
        loop = 1'b1;
        log_d.delete(); log_c.delete();
        drive_ctrl();
        start = 1'b1; len = LW'(2);
        tick();
        start = 1'b0;
        repeat (25) begin drive_ctrl(); tick(); end
        chk("loop_d0", 32'(log_d[0]), 32'd7);
        chk("loop_d1", 32'(log_d[1]), 32'd9);
        chk("loop_d2", 32'(log_d[2]), 32'd7);
        chk("loop_d3", 32'(log_d[3]), 32'd9);
        chk("loop_done", 32'(done), 32'd0);
        chk("loop_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        loop = 1'b0;
        chk("loop_rst_valid", 32'(digit_valid), 32'd0);
        chk("loop_rst_busy", 32'(busy), 32'd0);
        chk("loop_rst_digit", 32'(digit), 32'd0);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_seq_ctrl.md
Name: id_seq_ctrl

Overview:
- Controller that sequences a 4-bit ID digit stream for the display path.
- Holds a writable digit table of DEPTH entries and, on command, emits entries 0..len-1 one at a time over a valid/ready handshake.
- Inserts a programmable inter-digit gap and supports abort and freeze.
- Sits between the board switch/button logic and the digit display datapath, replacing the free-running hard-wired ID counter with a commanded sequencer.

Parameters:
- DEPTH, 8, number of digit table entries (2..16).
- TICK_DIV, 4, idle cycles between an accepted digit and the next valid (>=1).
- AW, $clog2(DEPTH), table address width (derived, do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write address
- cfg_data  in  4  table write data
- len  in  AW+1  sequence length, sampled on accepted start
- start  in  1  begin sequence (level sampled per cycle)
- stop  in  1  abort sequence
- hold  in  1  freeze gap counter
- digit  out  4  current digit
- digit_valid  out  1  digit is presented
- digit_ready  in  1  downstream accepts digit
- idx  out  AW  table index of current/next digit
- busy  out  1  sequence in progress
- done  out  1  sticky: last sequence completed normally

Behaviour:
- Reset: state IDLE; digit=0, digit_valid=0, idx=0, busy=0, done=0; all table entries cleared to 0; gap counter 0.
- States: IDLE, EMIT, GAP (enum in package).
- IDLE:
  - start=1 and stop=0 → latch len_q = min(len, DEPTH); idx=0; done=0.
  - len_q!=0 → EMIT next cycle.
  - len_q==0 → stay IDLE, done=1 next cycle.
- EMIT:
  - digit_valid=1, digit=table[idx], busy=1.
  - digit and idx are held stable while digit_ready=0.
  - Transfer = digit_valid & digit_ready.
  - Transfer with idx==len_q-1 → IDLE, done=1, idx=0.
  - Transfer otherwise → GAP, idx=idx+1, gap counter loaded TICK_DIV-1.
- GAP:
  - digit_valid=0, busy=1.
  - Counter decrements each cycle with hold=0, frozen with hold=1.
  - hold=0 and counter==0 → EMIT.
  - Gap is exactly TICK_DIV cycles with hold=0.
- Latency: first digit_valid 1 cycle after the accepted start.
- stop:
  - Highest priority in every state; stop=1 in EMIT/GAP → IDLE next cycle, idx=0, done unchanged (stays 0), digit_valid=0.
  - stop concurrent with a transfer: the downstream has consumed the digit, sequence still aborts, done not set.
- start while busy is ignored. start and stop in the same cycle in IDLE → remain IDLE.
- cfg writes:
  - Accepted only when busy=0; ignored while busy.
  - Write visible to a start issued the following cycle.
  - cfg_addr >= DEPTH is ignored.
- Reset mid-sequence returns to the full reset state on the next edge, regardless of other inputs.
- Width rule: len compared as unsigned AW+1 bits; idx wraps only via explicit return to 0, never by overflow.

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit), sampled at transfer of the last digit.
  - loop=1 → GAP with idx=0 instead of IDLE; done stays 0; sequence repeats until stop.
  - loop=0 → normal completion.
- Undefined: port absent; always one-shot behaviour as above.

Decomposition:
- Package id_seq_pkg:
  - typedef digit_t (logic [3:0])
  - enum seq_state_t {IDLE, EMIT, GAP}
  - constant DIGIT_RESET = 4'd0
- One natural sub-module: gap_timer (load value, hold input, zero flag), instanced once for the GAP countdown.

Test Plan:
- Load table {3,1,4,1,5}, len=5, digit_ready=1, TICK_DIV=4 → digits 3,1,4,1,5 each valid for one cycle, 4-cycle gaps; done=1 one cycle after the digit 5 transfer; busy=0.
- Same table, digit_ready low 3 cycles on idx=2 → digit=4, idx=2 held stable for those cycles; sequence resumes unchanged.
- stop asserted in GAP after idx=1 → IDLE next cycle, digit_valid=0, idx=0, done=0; subsequent start replays from 3.
- len=0 start → no digit_valid ever; done=1 next cycle. len=12 with DEPTH=8 → exactly 8 digits emitted.
- hold=1 for 5 cycles during a gap → next digit_valid delayed by exactly 5 cycles; cfg_we issued while busy → table entry unchanged on replay.
- SEQ_LOOP_EN, loop=1, len=2 table {7,9} → 7,9,7,9... repeating with gaps, done stays 0; reset mid-stream → all outputs 0 next cycle.
